// File: rtl/cpu_run_ctrl.sv
// Run-control sequencer for the prototype soft CPU: turns front-panel switch/buttons
// into a single clock enable with free-run, single-step, N-cycle burst and PC breakpoint.
module cpu_run_ctrl #(
    parameter int PC_W        = 8,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             RUN_SW,
    input  logic             STEP_BTN,
    input  logic             BURST_BTN,
    input  logic [CNT_W-1:0] BURST_LEN,
    input  logic             BP_EN,
    input  logic [PC_W-1:0]  BP_ADDR,
    input  logic [PC_W-1:0]  PC,
    output logic             CPU_EN,
    output logic             HALTED,
    output logic             BP_HIT,
    output logic [2:0]       STATE,
    output logic [CNT_W-1:0] CYCLE_CNT
);

    typedef enum logic [2:0] {
        S_HALT  = 3'd0,
        S_STEP  = 3'd1,
        S_BURST = 3'd2,
        S_RUN   = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] run_sync, step_sync, burst_sync, fill_pipe;
    logic step_prev, burst_prev;
    logic run_s, step_s, burst_s, filled;
    logic step_pulse, burst_pulse, burst_go;
    logic [CNT_W-1:0] remaining;
    logic skip, load_burst, active, bp_match, bp_stop, cpu_en;
    logic halted_q, bp_hit_q;

    assign run_s   = run_sync[SYNC_STAGES-1];
    assign step_s  = step_sync[SYNC_STAGES-1];
    assign burst_s = burst_sync[SYNC_STAGES-1];
    assign filled  = fill_pipe[SYNC_STAGES-1];

    // Edge history is pinned high until the chains have flushed their reset zeros,
    // otherwise a button held through reset would look like a fresh 0->1 edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            run_sync   <= '0;
            step_sync  <= '0;
            burst_sync <= '0;
            fill_pipe  <= '0;
            step_prev  <= 1'b1;
            burst_prev <= 1'b1;
        end else begin
            run_sync   <= {run_sync[SYNC_STAGES-2:0], RUN_SW};
            step_sync  <= {step_sync[SYNC_STAGES-2:0], STEP_BTN};
            burst_sync <= {burst_sync[SYNC_STAGES-2:0], BURST_BTN};
            fill_pipe  <= {fill_pipe[SYNC_STAGES-2:0], 1'b1};
            step_prev  <= filled ? step_s : 1'b1;
            burst_prev <= filled ? burst_s : 1'b1;
        end
    end

    assign step_pulse  = step_s & ~step_prev;
    assign burst_pulse = burst_s & ~burst_prev;
    assign burst_go    = burst_pulse & (BURST_LEN != '0);

    assign active   = (state_q == S_STEP) || (state_q == S_BURST) || (state_q == S_RUN);
    assign bp_match = BP_EN & (PC == BP_ADDR);
    assign bp_stop  = bp_match & ~skip & ((state_q == S_RUN) || (state_q == S_BURST));
    assign cpu_en   = active & ~bp_stop;

    always_comb begin
        state_d    = state_q;
        load_burst = 1'b0;
        unique case (state_q)
            S_HALT: begin
                if (run_s) begin
                    state_d = S_RUN;
                end else if (burst_go) begin
                    state_d    = S_BURST;
                    load_burst = 1'b1;
                end else if (step_pulse) begin
                    state_d = S_STEP;
                end
            end
            S_STEP: state_d = S_HALT;
            S_BURST: begin
                if (bp_stop)
                    state_d = S_BREAK;
                else if (remaining == CNT_W'(1))
                    state_d = S_HALT;
            end
            S_RUN: begin
                if (!run_s)
                    state_d = S_HALT;
                else if (bp_stop)
                    state_d = S_BREAK;
            end
            S_BREAK: begin
                if (!run_s) begin
                    state_d = S_HALT;
                end else if (burst_go) begin
                    state_d    = S_BURST;
                    load_burst = 1'b1;
                end else if (step_pulse) begin
                    state_d = S_STEP;
                end
            end
            default: state_d = S_HALT;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= S_HALT;
            remaining <= '0;
            skip      <= 1'b0;
            CYCLE_CNT <= '0;
            halted_q  <= 1'b1;
            bp_hit_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= (state_d == S_HALT) || (state_d == S_BREAK);
            bp_hit_q <= (state_d == S_BREAK);
            if (load_burst)
                remaining <= BURST_LEN;
            else if (cpu_en && state_q == S_BURST)
                remaining <= remaining - CNT_W'(1);
            // Skip lets the first instruction after (re)entry execute even at BP_ADDR.
            if ((state_d == S_RUN || state_d == S_BURST) && state_d != state_q)
                skip <= 1'b1;
            else if (cpu_en)
                skip <= 1'b0;
            if (cpu_en)
                CYCLE_CNT <= CYCLE_CNT + CNT_W'(1);
        end
    end

    assign CPU_EN = cpu_en;
    assign HALTED = halted_q;
    assign BP_HIT = bp_hit_q;
    assign STATE  = state_q;

endmodule
